// File: rtl/reg_shadow_bank.sv
// Register bank on the byte-serial register bus: double-buffered control registers
// with commit/revert/auto-commit, coherent live-counter snapshots and sticky event flags.
module reg_shadow_bank #(
   parameter int unsigned                          pBYTECNT_SIZE = 7,
   parameter logic [7:0]                           pBASE_ADDR    = 8'h60,
   parameter int unsigned                          pNUM_CTRL     = 4,
   parameter int unsigned                          pCTRL_BYTES   = 4,
   parameter logic [pNUM_CTRL*pCTRL_BYTES*8-1:0]   pCTRL_DEFAULT = '0,
   parameter int unsigned                          pNUM_LIVE     = 2,
   parameter int unsigned                          pNUM_STICKY   = 8
) (
   input  logic                                 clk_usb,
   input  logic                                 reset_i,
   input  logic [7:0]                           reg_address,
   input  logic [pBYTECNT_SIZE-1:0]             reg_bytecnt,
   input  logic [7:0]                           reg_datai,
   output logic [7:0]                           reg_datao,
   input  logic                                 reg_read,
   input  logic                                 reg_write,
   output logic [pNUM_CTRL*pCTRL_BYTES*8-1:0]   ctrl_o,
   output logic                                 commit_o,
   input  logic [pNUM_LIVE*32-1:0]              live_i,
   input  logic [pNUM_STICKY-1:0]               event_i,
   output logic                                 flag_o
);

   localparam int unsigned LP_W        = pCTRL_BYTES * 8;
   localparam int unsigned LP_CW       = pNUM_CTRL * LP_W;
   localparam logic [7:0]  LP_OFF_CMD  = 8'(pNUM_CTRL);
   localparam logic [7:0]  LP_OFF_STKY = 8'(pNUM_CTRL + 1);
   localparam logic [7:0]  LP_OFF_MASK = 8'(pNUM_CTRL + 2);

   logic [LP_CW-1:0]        r_shadow;
   logic [LP_CW-1:0]        r_active;
   logic                    r_auto;
   logic                    r_commit;
   logic [pNUM_STICKY-1:0]  r_sticky;
   logic [pNUM_STICKY-1:0]  r_mask;
   logic                    r_flag;
   logic [pNUM_LIVE*32-1:0] r_snap;
   logic                    r_read_d;
   logic [7:0]              r_addr_d;

   logic [7:0]              w_offset;
   logic [31:0]             w_bidx;
   logic                    w_byte0;
   logic                    w_first;
   logic                    w_cap;
   logic                    w_pending;
   logic [31:0]             w_sticky32;
   logic [31:0]             w_mask32;

   logic [LP_CW-1:0]        w_shadow_nxt;
   logic [LP_CW-1:0]        w_active_nxt;
   logic                    w_auto_nxt;
   logic                    w_commit_nxt;
   logic [pNUM_STICKY-1:0]  w_clr;
   logic [pNUM_STICKY-1:0]  w_sticky_nxt;
   logic [pNUM_STICKY-1:0]  w_mask_nxt;
   logic [pNUM_LIVE*32-1:0] w_snap_nxt;

   assign w_offset   = reg_address - pBASE_ADDR;
   assign w_bidx     = 32'(reg_bytecnt);
   assign w_byte0    = (reg_bytecnt == '0);
   // First cycle of a read: strobe rising, or the address moved while reading.
   assign w_first    = reg_read & (~r_read_d | (reg_address != r_addr_d));
   assign w_cap      = w_first & w_byte0;
   assign w_pending  = (r_shadow != r_active);
   assign w_sticky32 = 32'(r_sticky);
   assign w_mask32   = 32'(r_mask);

   assign ctrl_o   = r_active;
   assign commit_o = r_commit;
   assign flag_o   = r_flag;

   // Read data mux; zero when not reading or when the offset/byte is unmapped.
   always_comb begin
      reg_datao = '0;
      if (reg_read) begin
         for (int k = 0; k < pNUM_CTRL; k++) begin
            for (int b = 0; b < pCTRL_BYTES; b++) begin
               if (w_offset == 8'(k) && w_bidx == 32'(b))
                  reg_datao = r_shadow[k*LP_W + b*8 +: 8];
            end
         end
         if (w_offset == LP_OFF_CMD && w_byte0)
            reg_datao = {5'b0, w_pending, r_auto, 1'b0};
         for (int b = 0; b < 4; b++) begin
            if (w_bidx == 32'(b)) begin
               if (w_offset == LP_OFF_STKY) reg_datao = w_sticky32[b*8 +: 8];
               if (w_offset == LP_OFF_MASK) reg_datao = w_mask32[b*8 +: 8];
            end
         end
         for (int j = 0; j < pNUM_LIVE; j++) begin
            for (int b = 0; b < 4; b++) begin
               if (w_offset == 8'(pNUM_CTRL + 3 + j) && w_bidx == 32'(b)) begin
                  if (b == 0 && w_first)
                     reg_datao = live_i[j*32 +: 8];
                  else
                     reg_datao = r_snap[j*32 + b*8 +: 8];
               end
            end
         end
      end
   end

   // Next-state for control, sticky, mask and snapshot registers.
   always_comb begin
      w_shadow_nxt = r_shadow;
      w_active_nxt = r_active;
      w_auto_nxt   = r_auto;
      w_commit_nxt = 1'b0;
      w_clr        = '0;
      w_mask_nxt   = r_mask;
      w_snap_nxt   = r_snap;

      if (reg_write) begin
         for (int k = 0; k < pNUM_CTRL; k++) begin
            for (int b = 0; b < pCTRL_BYTES; b++) begin
               if (w_offset == 8'(k) && w_bidx == 32'(b)) begin
                  w_shadow_nxt[k*LP_W + b*8 +: 8] = reg_datai;
                  if (r_auto) begin
                     w_active_nxt[k*LP_W + b*8 +: 8] = reg_datai;
                     w_commit_nxt                    = 1'b1;
                  end
               end
            end
         end
         // Commit takes priority over revert when both bits are set.
         if (w_offset == LP_OFF_CMD && w_byte0) begin
            w_auto_nxt = reg_datai[1];
            if (reg_datai[0]) begin
               w_active_nxt = r_shadow;
               w_commit_nxt = 1'b1;
            end else if (reg_datai[2]) begin
               w_shadow_nxt = r_active;
            end
         end
         for (int i = 0; i < pNUM_STICKY; i++) begin
            if (w_bidx == 32'(i / 8)) begin
               if (w_offset == LP_OFF_STKY) w_clr[i]      = reg_datai[i % 8];
               if (w_offset == LP_OFF_MASK) w_mask_nxt[i] = reg_datai[i % 8];
            end
         end
      end

      // New events win over a same-cycle clear.
      w_sticky_nxt = event_i | (r_sticky & ~w_clr);

      for (int j = 0; j < pNUM_LIVE; j++) begin
         if (w_cap && w_offset == 8'(pNUM_CTRL + 3 + j))
            w_snap_nxt[j*32 +: 32] = live_i[j*32 +: 32];
      end
   end

   always_ff @(posedge clk_usb or posedge reset_i) begin
      if (reset_i) begin
         r_shadow <= pCTRL_DEFAULT;
         r_active <= pCTRL_DEFAULT;
         r_auto   <= 1'b0;
         r_commit <= 1'b0;
         r_sticky <= '0;
         r_mask   <= '0;
         r_flag   <= 1'b0;
         r_snap   <= '0;
         r_read_d <= 1'b0;
         r_addr_d <= '0;
      end else begin
         r_shadow <= w_shadow_nxt;
         r_active <= w_active_nxt;
         r_auto   <= w_auto_nxt;
         r_commit <= w_commit_nxt;
         r_sticky <= w_sticky_nxt;
         r_mask   <= w_mask_nxt;
         r_flag   <= |(r_sticky & r_mask);
         r_snap   <= w_snap_nxt;
         r_read_d <= reg_read;
         r_addr_d <= reg_address;
      end
   end

endmodule

// File: tb/tb_reg_shadow_bank.sv
// Directed bench for reg_shadow_bank: reset values, commit/revert/auto, snapshots,
// sticky flags and asynchronous reset mid-transaction.
module tb_reg_shadow_bank;

   localparam logic [127:0] LP_DEF = {96'h0, 32'h1234_C0DE};

   logic         clk_usb;
   logic         reset_i;
   logic [7:0]   reg_address;
   logic [6:0]   reg_bytecnt;
   logic [7:0]   reg_datai;
   logic [7:0]   reg_datao;
   logic         reg_read;
   logic         reg_write;
   logic [127:0] ctrl_o;
   logic         commit_o;
   logic [63:0]  live_i;
   logic [7:0]   event_i;
   logic         flag_o;

   logic [31:0]  live0;
   logic [31:0]  live1;
   int           n_checks;
   int           n_pass;

   assign live_i = {live1, live0};

   reg_shadow_bank #(
      .pBYTECNT_SIZE (7),
      .pBASE_ADDR    (8'h60),
      .pNUM_CTRL     (4),
      .pCTRL_BYTES   (4),
      .pCTRL_DEFAULT (LP_DEF),
      .pNUM_LIVE     (2),
      .pNUM_STICKY   (8)
   ) u_dut (
      .clk_usb     (clk_usb),
      .reset_i     (reset_i),
      .reg_address (reg_address),
      .reg_bytecnt (reg_bytecnt),
      .reg_datai   (reg_datai),
      .reg_datao   (reg_datao),
      .reg_read    (reg_read),
      .reg_write   (reg_write),
      .ctrl_o      (ctrl_o),
      .commit_o    (commit_o),
      .live_i      (live_i),
      .event_i     (event_i),
      .flag_o      (flag_o)
   );

   initial begin
      clk_usb = 1'b0;
      forever #5 clk_usb = ~clk_usb;
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   // Advance one clock; inputs change 1ns after the edge, the live counter ticks there too.
   task automatic tick();
      @(posedge clk_usb);
      #1;
      live0 = live0 + 32'd1;
   endtask

   task automatic wr(input logic [7:0] a, input int b, input logic [7:0] d);
      reg_address = a;
      reg_bytecnt = 7'(b);
      reg_datai   = d;
      reg_write   = 1'b1;
      tick();
      reg_write   = 1'b0;
   endtask

   task automatic chk_rd(input string tag, input logic [7:0] a, input int b, input logic [7:0] exp);
      reg_address = a;
      reg_bytecnt = 7'(b);
      reg_read    = 1'b1;
      #1;
      check(tag, 128'(reg_datao), 128'(exp));
      tick();
      reg_read    = 1'b0;
   endtask

   task automatic read_live(input logic [7:0] a, input bit use_live0,
                            output logic [31:0] got, output logic [31:0] cap);
      logic [31:0] v;
      v   = '0;
      cap = '0;
      for (int b = 0; b < 4; b++) begin
         reg_address = a;
         reg_bytecnt = 7'(b);
         reg_read    = 1'b1;
         #1;
         if (b == 0) cap = use_live0 ? live0 : live1;
         v[b*8 +: 8] = reg_datao;
         tick();
         reg_read = 1'b0;
         repeat (3) tick();
      end
      got = v;
   endtask

   initial begin
      logic [31:0] got;
      logic [31:0] cap;
      n_checks    = 0;
      n_pass      = 0;
      reset_i     = 1'b1;
      reg_address = '0;
      reg_bytecnt = '0;
      reg_datai   = '0;
      reg_read    = 1'b0;
      reg_write   = 1'b0;
      event_i     = '0;
      live0       = 32'h0000_0100;
      live1       = 32'hCAFE_F00D;
      repeat (3) tick();
      reset_i = 1'b0;
      tick();

      // Reset state
      chk_rd("ctrl0_b0", 8'h60, 0, 8'hDE);
      chk_rd("ctrl0_b1", 8'h60, 1, 8'hC0);
      chk_rd("ctrl0_b2", 8'h60, 2, 8'h34);
      chk_rd("ctrl0_b3", 8'h60, 3, 8'h12);
      chk_rd("ctrl0_b4_oob", 8'h60, 4, 8'h00);
      check("rst_ctrl_o", ctrl_o, LP_DEF);
      chk_rd("rst_cmd", 8'h64, 0, 8'h00);
      check("rst_flag", 128'(flag_o), 128'(1'b0));
      check("rst_commit", 128'(commit_o), 128'(1'b0));
      chk_rd("unmapped", 8'h70, 0, 8'h00);
      reg_address = 8'h60; reg_bytecnt = '0; reg_read = 1'b0;
      #1;
      check("noread_zero", 128'(reg_datao), 128'(8'h00));

      // Commit
      wr(8'h61, 0, 8'h78); wr(8'h61, 1, 8'h56); wr(8'h61, 2, 8'h34); wr(8'h61, 3, 8'h12);
      check("shadow_only", ctrl_o, LP_DEF);
      chk_rd("cmd_pending", 8'h64, 0, 8'h04);
      wr(8'h64, 0, 8'h01);
      check("commit_ctrl1", 128'(ctrl_o[63:32]), 128'(32'h1234_5678));
      check("commit_pulse", 128'(commit_o), 128'(1'b1));
      tick();
      check("commit_pulse_end", 128'(commit_o), 128'(1'b0));
      chk_rd("cmd_clean", 8'h64, 0, 8'h00);
      wr(8'h61, 0, 8'h9A);
      wr(8'h64, 0, 8'h05);
      check("commit_wins_ctrl1", 128'(ctrl_o[63:32]), 128'(32'h1234_569A));
      check("commit_wins_pulse", 128'(commit_o), 128'(1'b1));
      chk_rd("commit_wins_shadow", 8'h61, 0, 8'h9A);
      chk_rd("commit_wins_cmd", 8'h64, 0, 8'h00);

      // Revert and auto-commit
      wr(8'h60, 0, 8'hAA);
      chk_rd("shadow_aa", 8'h60, 0, 8'hAA);
      chk_rd("cmd_pend2", 8'h64, 0, 8'h04);
      wr(8'h64, 0, 8'h04);
      check("revert_nopulse", 128'(commit_o), 128'(1'b0));
      chk_rd("revert_shadow", 8'h60, 0, 8'hDE);
      chk_rd("revert_cmd", 8'h64, 0, 8'h00);
      check("revert_ctrl0", 128'(ctrl_o[31:0]), 128'(32'h1234_C0DE));
      wr(8'h64, 0, 8'h02);
      check("auto_set_nopulse", 128'(commit_o), 128'(1'b0));
      chk_rd("cmd_auto", 8'h64, 0, 8'h02);
      wr(8'h60, 1, 8'h55);
      check("auto_ctrl0", 128'(ctrl_o[31:0]), 128'(32'h1234_55DE));
      check("auto_pulse", 128'(commit_o), 128'(1'b1));
      tick();
      check("auto_pulse_end", 128'(commit_o), 128'(1'b0));
      chk_rd("cmd_auto_clean", 8'h64, 0, 8'h02);

      // Snapshot coherency across a carry
      live0 = 32'h00FF_FFFE;
      read_live(8'h67, 1'b1, got, cap);
      check("live0_snap", 128'(got), 128'(cap));
      check("live0_cap_val", 128'(cap), 128'(32'h00FF_FFFE));
      read_live(8'h68, 1'b0, got, cap);
      check("live1_snap", 128'(got), 128'(32'hCAFE_F00D));
      reg_address = 8'h67; reg_bytecnt = '0; reg_read = 1'b1;
      #1;
      cap = live0;
      check("hold_first", 128'(reg_datao), 128'(cap[7:0]));
      tick(); tick();
      #1;
      check("hold_norecap", 128'(reg_datao), 128'(cap[7:0]));
      reg_read = 1'b0;
      tick();

      // Sticky flags
      wr(8'h66, 0, 8'h80);
      wr(8'h66, 1, 8'hFF);
      chk_rd("mask_b0", 8'h66, 0, 8'h80);
      chk_rd("mask_b1_oob", 8'h66, 1, 8'h00);
      event_i = 8'h80;
      tick();
      event_i = 8'h00;
      check("flag_lag", 128'(flag_o), 128'(1'b0));
      chk_rd("sticky_set", 8'h65, 0, 8'h80);
      check("flag_set", 128'(flag_o), 128'(1'b1));
      event_i = 8'h80;
      wr(8'h65, 0, 8'h80);
      event_i = 8'h00;
      chk_rd("sticky_set_wins", 8'h65, 0, 8'h80);
      wr(8'h65, 0, 8'h80);
      check("flag_hold_after_clr", 128'(flag_o), 128'(1'b1));
      chk_rd("sticky_clr", 8'h65, 0, 8'h00);
      check("flag_clr", 128'(flag_o), 128'(1'b0));
      event_i = 8'h01;
      tick();
      event_i = 8'h00;
      tick(); tick();
      check("flag_masked", 128'(flag_o), 128'(1'b0));
      chk_rd("sticky_unmasked", 8'h65, 0, 8'h01);

      // Asynchronous reset mid auto-commit and mid LIVE read
      event_i = 8'h80;
      tick();
      event_i = 8'h00;
      tick();
      check("pre_rst_flag", 128'(flag_o), 128'(1'b1));
      wr(8'h62, 0, 8'h77);
      check("pre_rst_ctrl2", 128'(ctrl_o[71:64]), 128'(8'h77));
      check("pre_rst_commit", 128'(commit_o), 128'(1'b1));
      reg_address = 8'h68; reg_bytecnt = 7'd3; reg_read = 1'b1;
      #1;
      check("pre_rst_live1_b3", 128'(reg_datao), 128'(8'hCA));
      #1;
      reset_i = 1'b1;
      #1;
      check("rst_async_ctrl", ctrl_o, LP_DEF);
      check("rst_async_commit", 128'(commit_o), 128'(1'b0));
      check("rst_async_flag", 128'(flag_o), 128'(1'b0));
      check("rst_async_snap", 128'(reg_datao), 128'(8'h00));
      reg_read = 1'b0;
      tick();
      reset_i = 1'b0;
      tick();
      chk_rd("post_rst_cmd", 8'h64, 0, 8'h00);
      chk_rd("post_rst_sticky", 8'h65, 0, 8'h00);
      chk_rd("post_rst_ctrl2", 8'h62, 0, 8'h00);
      chk_rd("post_rst_ctrl0", 8'h60, 1, 8'hC0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
